// File: rtl/div_pkg.sv
// Shared definitions for the divider block: field widths, iteration count and
// the divider FSM state encoding.
package div_pkg;

  localparam int unsigned DividendW = 16;
  localparam int unsigned DivisorW  = 8;
  localparam int unsigned DinW      = DividendW + DivisorW;      // {dividend, divisor}
  localparam int unsigned ResultW   = 1 + DividendW + DivisorW;  // {dz, quotient, remainder}
  localparam int unsigned NumIter   = 16;
  localparam int unsigned IterW     = $clog2(NumIter);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } div_state_e;

endpackage

// File: rtl/div_core.sv
// Iterative restoring divider, one quotient bit per cycle.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   start_i        an operand pair is available (accepted while not busy)
//   dividend_i     16-bit dividend
//   divisor_i      8-bit divisor
//   busy_o         core is not idle; start_i is not accepted
//   done_o         result_o is valid and waiting for ack_i
//   ack_i          result taken this cycle; core returns to idle
//   result_o       {dz, quotient[15:0], remainder[7:0]}
module div_core
  import div_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [DividendW-1:0] dividend_i,
  input  logic [DivisorW-1:0]  divisor_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 ack_i,
  output logic [ResultW-1:0]   result_o
);

  div_state_e           state_q, state_d;
  logic [DividendW-1:0] quo_q, quo_d;  // holds the dividend, shifts into the quotient
  logic [DivisorW-1:0]  rem_q, rem_d;  // partial remainder, always below the divisor
  logic [DivisorW-1:0]  dsr_q, dsr_d;
  logic                 dz_q, dz_d;
  logic [IterW-1:0]     cnt_q, cnt_d;

  logic [DivisorW:0]    rem_sh;
  logic                 neg;

  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;

    rem_sh  = {rem_q, quo_q[DividendW-1]};
    neg     = rem_sh < {1'b0, dsr_q};

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          quo_d   = dividend_i;
          rem_d   = '0;
          dsr_d   = divisor_i;
          dz_d    = (divisor_i == '0);
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (dz_q) begin
          // Divide by zero: all-ones quotient, low dividend byte as remainder.
          rem_d   = quo_q[DivisorW-1:0];
          quo_d   = '1;
          state_d = StDone;
        end else begin
          // A negative trial difference keeps the shifted remainder (restore).
          rem_d = neg ? rem_sh[DivisorW-1:0] : DivisorW'(rem_sh - {1'b0, dsr_q});
          quo_d = {quo_q[DividendW-2:0], ~neg};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == IterW'(NumIter - 1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (ack_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      quo_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign done_o   = (state_q == StDone);
  assign result_o = {dz_q, quo_q, rem_q};

endmodule

// File: rtl/div_unit.sv
// Buffered divider: operand FIFO -> iterative divider core -> result FIFO.
//
// Ports:
//   CLK    clock, rising edge
//   RST    asynchronous active-low reset
//   DIN    {dividend[15:0], divisor[7:0]}, pushed when WR=1 and FULL=0
//   WR     write strobe
//   FULL   operand buffer holds DEPTH entries
//   RD     read strobe, pops a result when EMPTY=0
//   DOUT   {dz, quotient[15:0], remainder[7:0]}, held between reads
//   VALID  DOUT carries the result popped on the previous edge
//   EMPTY  result buffer holds no entries
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DinW-1:0]    DIN,
  input  logic               WR,
  output logic               FULL,
  input  logic               RD,
  output logic [ResultW-1:0] DOUT,
  output logic               VALID,
  output logic               EMPTY
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Operand buffer
  logic [DinW-1:0] ib_mem [DEPTH];
  logic [PtrW-1:0] ib_wptr_q, ib_rptr_q;
  logic [CntW-1:0] ib_cnt_q;
  logic [DinW-1:0] ib_head;
  logic            ib_push, ib_pop;

  // Result buffer
  logic [ResultW-1:0] ob_mem [DEPTH];
  logic [PtrW-1:0]    ob_wptr_q, ob_rptr_q;
  logic [CntW-1:0]    ob_cnt_q;
  logic               ob_full, ob_push, ob_pop;

  logic [ResultW-1:0] dout_q;
  logic               valid_q;

  logic               core_start, core_busy, core_done;
  logic [ResultW-1:0] core_result;

  assign FULL    = (ib_cnt_q == CntW'(DEPTH));
  assign EMPTY   = (ob_cnt_q == '0);
  assign ob_full = (ob_cnt_q == CntW'(DEPTH));

  assign ib_head    = ib_mem[ib_rptr_q];
  assign core_start = (ib_cnt_q != '0);

  assign ib_push = WR && !FULL;
  assign ib_pop  = core_start && !core_busy;  // the core captures the head as it leaves idle
  assign ob_push = core_done && !ob_full;
  assign ob_pop  = RD && !EMPTY;

  div_core u_core (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .start_i    (core_start),
    .dividend_i (ib_head[DinW-1:DivisorW]),
    .divisor_i  (ib_head[DivisorW-1:0]),
    .busy_o     (core_busy),
    .done_o     (core_done),
    .ack_i      (ob_push),
    .result_o   (core_result)
  );

  always_ff @(posedge CLK) begin
    if (ib_push) begin
      ib_mem[ib_wptr_q] <= DIN;
    end
    if (ob_push) begin
      ob_mem[ob_wptr_q] <= core_result;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ib_wptr_q <= '0;
      ib_rptr_q <= '0;
      ib_cnt_q  <= '0;
      ob_wptr_q <= '0;
      ob_rptr_q <= '0;
      ob_cnt_q  <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      if (ib_push) ib_wptr_q <= ptr_inc(ib_wptr_q);
      if (ib_pop)  ib_rptr_q <= ptr_inc(ib_rptr_q);
      if (ib_push && !ib_pop) begin
        ib_cnt_q <= ib_cnt_q + 1'b1;
      end else if (!ib_push && ib_pop) begin
        ib_cnt_q <= ib_cnt_q - 1'b1;
      end

      if (ob_push) ob_wptr_q <= ptr_inc(ob_wptr_q);
      if (ob_pop)  ob_rptr_q <= ptr_inc(ob_rptr_q);
      if (ob_push && !ob_pop) begin
        ob_cnt_q <= ob_cnt_q + 1'b1;
      end else if (!ob_push && ob_pop) begin
        ob_cnt_q <= ob_cnt_q - 1'b1;
      end

      valid_q <= ob_pop;
      if (ob_pop) begin
        dout_q <= ob_mem[ob_rptr_q];
      end
    end
  end

  assign DOUT  = dout_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed scenarios plus a randomized
// run scored against an arithmetic reference model.
module tb_div_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [23:0] DIN;
  logic        WR;
  logic        FULL;
  logic        RD;
  logic [24:0] DOUT;
  logic        VALID;
  logic        EMPTY;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.DEPTH(4)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .DIN   (DIN),
    .WR    (WR),
    .FULL  (FULL),
    .RD    (RD),
    .DOUT  (DOUT),
    .VALID (VALID),
    .EMPTY (EMPTY)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division on the two fields.
  function automatic logic [24:0] div_ref(input logic [23:0] din);
    logic [15:0] a;
    logic [7:0]  b;
    a = din[23:8];
    b = din[7:0];
    if (b == 8'd0) return {1'b1, 16'hFFFF, a[7:0]};
    return {1'b0, 16'(a / b), 8'(a % b)};
  endfunction

  // All stimulus changes happen at the falling edge; one step = one rising edge.
  task automatic step();
    @(negedge CLK);
  endtask

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!EMPTY) break;
      step();
    end
    check_eq("wait_not_empty", {31'd0, EMPTY}, 32'd0);
  endtask

  task automatic read_check(input string tag, input logic [24:0] exp);
    RD = 1'b1;
    step();
    RD = 1'b0;
    check_eq({tag, "_valid"}, {31'd0, VALID}, 32'd1);
    check_eq({tag, "_dout"}, {7'd0, DOUT}, {7'd0, exp});
    step();
    check_eq({tag, "_valid_drop"}, {31'd0, VALID}, 32'd0);
    check_eq({tag, "_dout_hold"}, {7'd0, DOUT}, {7'd0, exp});
  endtask

  logic [23:0] items [6];
  logic [24:0] exp_q [$];
  logic [24:0] exp_v;

  initial begin
    RST = 1'b0;
    WR  = 1'b0;
    RD  = 1'b0;
    DIN = '0;
    repeat (3) step();
    check_eq("rst_empty", {31'd0, EMPTY}, 32'd1);
    check_eq("rst_full", {31'd0, FULL}, 32'd0);
    check_eq("rst_valid", {31'd0, VALID}, 32'd0);
    check_eq("rst_dout", {7'd0, DOUT}, 32'd0);
    RST = 1'b1;
    step();

    // Single division with EMPTY latency.
    DIN = 24'h1234_10;
    WR  = 1'b1;
    step();
    WR = 1'b0;
    repeat (17) step();
    check_eq("lat_empty_17", {31'd0, EMPTY}, 32'd1);
    step();
    check_eq("lat_empty_18", {31'd0, EMPTY}, 32'd0);
    read_check("basic", 25'h0_0123_04);
    RD = 1'b1;  // read while empty is ignored
    step();
    RD = 1'b0;
    check_eq("rd_empty_valid", {31'd0, VALID}, 32'd0);

    // Two back-to-back writes come out in order.
    DIN = 24'hFFFF_FF;
    WR  = 1'b1;
    step();
    DIN = 24'h0064_07;
    step();
    WR = 1'b0;
    wait_ready(60);
    read_check("pair0", 25'h0_0101_00);
    wait_ready(60);
    read_check("pair1", 25'h0_000E_02);

    // Divide by zero.
    DIN = 24'h00C8_00;
    WR  = 1'b1;
    step();
    WR = 1'b0;
    wait_ready(60);
    read_check("dz", 25'h1_FFFF_C8);

    // Fill both buffers: FULL after the 5th write, 6th dropped, core parked in DONE.
    items[0] = 24'h1000_03;
    items[1] = 24'hABCD_00;
    items[2] = 24'h7FFF_80;
    items[3] = 24'h0005_09;
    items[4] = 24'hFFFF_01;
    items[5] = 24'h4242_42;
    for (int i = 0; i < 6; i++) begin
      DIN = items[i];
      WR  = 1'b1;
      step();
      check_eq($sformatf("full_after_wr%0d", i), {31'd0, FULL}, (i >= 4) ? 32'd1 : 32'd0);
    end
    WR = 1'b0;
    repeat (110) step();
    check_eq("fill_out_nonempty", {31'd0, EMPTY}, 32'd0);
    check_eq("fill_in_drained", {31'd0, FULL}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      wait_ready(60);
      read_check($sformatf("drain%0d", k), div_ref(items[k]));
    end
    repeat (60) step();
    check_eq("drain_no_extra", {31'd0, EMPTY}, 32'd1);

    // Reset in the middle of a division, with more work queued.
    DIN = 24'h1234_10;
    WR  = 1'b1;
    step();
    DIN = 24'h5555_05;
    step();
    WR = 1'b0;
    repeat (8) step();
    #2 RST = 1'b0;
    #1;
    check_eq("mid_rst_empty", {31'd0, EMPTY}, 32'd1);
    check_eq("mid_rst_full", {31'd0, FULL}, 32'd0);
    check_eq("mid_rst_valid", {31'd0, VALID}, 32'd0);
    check_eq("mid_rst_dout", {7'd0, DOUT}, 32'd0);
    step();
    RST = 1'b1;
    step();
    DIN = 24'h0009_03;
    WR  = 1'b1;
    step();
    WR = 1'b0;
    wait_ready(60);
    read_check("post_rst", 25'h0_0003_00);
    repeat (60) step();
    check_eq("post_rst_no_stale", {31'd0, EMPTY}, 32'd1);

    // Randomized traffic with independent WR/RD against the reference queue.
    begin
      int   sent    = 0;
      int   cycles  = 0;
      logic rd_pend = 1'b0;
      logic [23:0] d;
      while ((sent < 40 || exp_q.size() != 0 || rd_pend) && cycles < 6000) begin
        if (rd_pend) begin
          exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          check_eq("rand_valid", {31'd0, VALID}, 32'd1);
          check_eq("rand_dout", {7'd0, DOUT}, {7'd0, exp_v});
        end else if (VALID !== 1'b0) begin
          check_eq("rand_valid_idle", {31'd0, VALID}, 32'd0);
        end
        WR = 1'b0;
        if (sent < 40 && $urandom_range(0, 2) != 0) begin
          d[23:8] = 16'($urandom_range(0, 65535));
          d[7:0]  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
          DIN = d;
          WR  = 1'b1;
          if (!FULL) begin
            exp_q.push_back(div_ref(d));
            sent++;
          end
        end
        RD      = ($urandom_range(0, 1) != 0);
        rd_pend = RD && !EMPTY;
        step();
        cycles++;
      end
      WR = 1'b0;
      RD = 1'b0;
      check_eq("rand_all_results", exp_q.size(), 32'd0);
      check_eq("rand_all_sent", sent, 32'd40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, setting the entry count of each of the input and output buffers.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port DIN, input, 24 bits: {dividend[15:0], divisor[7:0]}.
REQ-005 SHALL have port WR, input, 1 bit: write strobe for DIN.
REQ-006 SHALL have port FULL, output, 1 bit: input buffer holds DEPTH entries.
REQ-007 SHALL have port RD, input, 1 bit: read strobe for the result buffer.
REQ-008 SHALL have port DOUT, output, 25 bits: {dz, quotient[15:0], remainder[7:0]}.
REQ-009 SHALL have port VALID, output, 1 bit: DOUT carries a popped result this cycle.
REQ-010 SHALL have port EMPTY, output, 1 bit: result buffer holds no entries.

Function
REQ-011 SHALL push DIN into the input buffer on a rising edge where WR=1 and FULL=0; WR while FULL=1 is dropped and buffer contents are unchanged.
REQ-012 SHALL pop the output buffer on a rising edge where RD=1 and EMPTY=0, driving DOUT with the popped entry and VALID=1 for exactly the following cycle; RD while EMPTY=1 is ignored and VALID stays 0.
REQ-013 SHALL hold DOUT at its last value while VALID=0.
REQ-014 SHALL implement the divider as an FSM with states IDLE, CALC and DONE.
REQ-015 SHALL, in IDLE, when the input buffer is non-empty, capture its head entry, pop it, clear the iteration count and go to CALC on the same edge.
REQ-016 SHALL, in CALC, perform one restoring-division step per cycle (shift the 9-bit partial remainder left, subtract the divisor, restore on negative, shift the quotient bit in) for exactly 16 cycles, then go to DONE.
REQ-017 SHALL, in DONE, push the result into the output buffer and go to IDLE when the output buffer is not full; otherwise it stays in DONE with the result held.
REQ-018 SHALL, for divisor 0, skip the iteration and produce dz=1, quotient 16'hFFFF and remainder dividend[7:0] in DONE on the edge after capture.
REQ-019 SHALL produce dz=0 for all non-zero divisors, with quotient*divisor+remainder = dividend and remainder < divisor.
REQ-020 SHALL, for a single write to an idle, empty block, deassert EMPTY after the 18th rising edge following the WR edge.
REQ-021 SHALL sustain one result per 18 cycles when the output buffer is drained.
REQ-022 SHALL handle a simultaneous push and pop on either buffer in one edge correctly, including when that buffer is full or empty, with its count unchanged.
REQ-023 SHALL wrap buffer pointers modulo DEPTH.
REQ-024 SHALL let WR, RD and the FSM proceed independently in the same cycle.

Reset
REQ-025 SHALL, while RST=0, asynchronously clear both buffers and set FULL=0, EMPTY=1, VALID=0, DOUT=0 and the FSM to IDLE.
REQ-026 SHALL discard any division in progress or waiting in DONE when RST asserts.
REQ-027 SHALL leave the first push after RST deasserts unaffected by pre-reset state.

Structure
REQ-028 SHALL place the FSM state encoding, the field widths (dividend 16, divisor 8, result 25) and the iteration count 16 in a shared package div_pkg.
REQ-029 SHALL implement the iterative divider FSM as sub-module div_core with a start/busy/done handshake to the top level.
REQ-030 SHALL implement both buffers inline in div_unit, each with its own count register.

Verification
REQ-031 SHALL cover: write 24'h1234_10, then RD when EMPTY=0 -> DOUT=25'h0_0123_04 with VALID=1 for exactly one cycle, EMPTY low 18 edges after WR.
REQ-032 SHALL cover: writes 24'hFFFF_FF and 24'h0064_07 -> results 25'h0_0101_00 then 25'h0_000E_02, in write order.
REQ-033 SHALL cover: write 24'h00C8_00 -> DOUT=25'h1_FFFF_C8.
REQ-034 SHALL cover: 6 back-to-back writes with RD=0 -> FULL rises after the 5th write (one entry already in the core), the 6th write is dropped, and draining later yields exactly 5 results in order.
REQ-035 SHALL cover: output buffer full with the FSM in DONE, then one RD -> the held result is pushed on the next edge and no result is lost or duplicated.
REQ-036 SHALL cover: RST pulsed low 8 cycles into CALC -> EMPTY=1, FULL=0 and VALID=0 immediately, and a fresh write of 24'h0009_03 yields 25'h0_0003_00.
